// File: rtl/pam4_pkg.sv
// Shared types and constants for the PAM-4 adaptive slicer: symbol type,
// lock FSM states, nominal level placement and the margin threshold.
package pam4_pkg;

    typedef logic [1:0] symbol_t;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } slicer_state_t;

    localparam int MARGIN_DIV = 4;

    // Nominal levels sit at -3S/2, -S/2, +S/2, +3S/2 for indices 0..3.
    function automatic int nominal_level(input int idx, input int sep);
        return ((2 * idx - 3) * sep) / 2;
    endfunction

    function automatic int margin_of(input int sep);
        return sep / MARGIN_DIV;
    endfunction

endpackage

// File: rtl/pam4_level_tracker.sv
// One PAM-4 level estimate in fixed point (MU fractional bits): exponential
// moving-average step toward the sample, saturated, with reload to nominal.
module pam4_level_tracker #(
    parameter int W       = 8,
    parameter int MU      = 4,
    parameter int LW      = W + MU + 1,
    parameter int NOMINAL = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 reload,
    input  logic                 upd_en,
    input  logic signed [W-1:0]  sample,
    output logic signed [LW-1:0] level,
    output logic signed [LW-1:0] proposed
);

    localparam logic signed [LW-1:0] NOM_FX = LW'(NOMINAL * (2 ** MU));
    localparam logic signed [LW:0]   MAX_V  = (LW+1)'((2 ** (LW - 1)) - 1);
    localparam logic signed [LW:0]   MIN_V  = (LW+1)'(-(2 ** (LW - 1)));

    logic signed [LW:0] xs;
    logic signed [LW:0] diff;
    logic signed [LW:0] step;
    logic signed [LW:0] sum;

    // One extra bit of headroom so the step and sum can be clamped, not wrapped.
    always_comb begin
        xs   = (LW+1)'(sample) <<< MU;
        diff = xs - (LW+1)'(level);
        step = diff >>> MU;
        sum  = (LW+1)'(level) + step;
        if (sum > MAX_V) begin
            proposed = MAX_V[LW-1:0];
        end else if (sum < MIN_V) begin
            proposed = MIN_V[LW-1:0];
        end else begin
            proposed = sum[LW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rstn || reload) begin
            level <= NOM_FX;
        end else if (upd_en) begin
            level <= proposed;
        end
    end

endmodule

// File: rtl/pam4_adaptive_slicer.sv
// PAM-4 decision slicer with decision-directed level tracking and lock FSM.
// Define PAM4_SLICER_ADAPT_EN to enable level adaptation; otherwise levels are fixed at nominal.
module pam4_adaptive_slicer
    import pam4_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int MU_SHIFT          = 4,
    parameter int LOCK_COUNT        = 64,
    parameter int ERR_LIMIT         = 8
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic signed [SIGNAL_RESOLUTION-1:0] voltage_level_in,
    input  logic                                voltage_level_in_valid,
    output symbol_t                             symbol_out,
    output logic                                symbol_out_valid,
    output logic                                marginal_out,
    output logic                                locked,
    output logic [7:0]                          err_count
);

    localparam int W      = SIGNAL_RESOLUTION;
    localparam int CW     = $clog2(LOCK_COUNT + 1);
    localparam int MARGIN = margin_of(SYMBOL_SEPERATION);
    localparam logic signed [W+1:0] MARGIN_X = (W+2)'(MARGIN);

    logic signed [W:0]   lint [4];
    logic signed [W:0]   thr [3];
    logic signed [W+1:0] pair_sum;
    logic signed [W:0]   x_ext;
    logic signed [W+1:0] sel_dev;
    logic signed [W+1:0] sel_mag;
    symbol_t             sym_idx;
    logic                marginal;
    logic                lose_lock;

    slicer_state_t state_q, state_d;
    logic [CW-1:0] run_q, run_d;
    logic [CW-1:0] win_q, win_d;
    logic [7:0]    err_q, err_d, err_inc;

`ifdef PAM4_SLICER_ADAPT_EN
    localparam int LW = W + MU_SHIFT + 1;
    localparam logic signed [LW:0] MIN_GAP = (LW+1)'(MARGIN * (2 ** MU_SHIFT));

    logic signed [LW-1:0] lvl [4];
    logic signed [LW-1:0] prop [4];
    logic [3:0]           gap_ok;

    function automatic logic spaced(input logic signed [LW-1:0] lo,
                                    input logic signed [LW-1:0] hi);
        return ((LW+1)'(hi) - (LW+1)'(lo)) >= MIN_GAP;
    endfunction

    // A level only moves if it keeps at least S/4 to both neighbours,
    // which also keeps the four levels strictly ordered.
    always_comb begin
        gap_ok[0] = spaced(prop[0], lvl[1]);
        gap_ok[1] = spaced(lvl[0], prop[1]) && spaced(prop[1], lvl[2]);
        gap_ok[2] = spaced(lvl[1], prop[2]) && spaced(prop[2], lvl[3]);
        gap_ok[3] = spaced(lvl[2], prop[3]);
    end

    for (genvar g = 0; g < 4; g++) begin : g_track
        pam4_level_tracker #(
            .W      (W),
            .MU     (MU_SHIFT),
            .LW     (LW),
            .NOMINAL(nominal_level(g, SYMBOL_SEPERATION))
        ) u_track (
            .clk     (clk),
            .rstn    (rstn),
            .reload  (voltage_level_in_valid && lose_lock),
            .upd_en  (voltage_level_in_valid && (sym_idx == 2'(g)) && gap_ok[g]),
            .sample  (voltage_level_in),
            .level   (lvl[g]),
            .proposed(prop[g])
        );
        assign lint[g] = lvl[g][LW-1:MU_SHIFT];
    end
`else
    // Fixed-point nominal truncated to integer exactly as the adaptive path does.
    for (genvar g = 0; g < 4; g++) begin : g_fixed
        assign lint[g] = (W+1)'((nominal_level(g, SYMBOL_SEPERATION) * (2 ** MU_SHIFT)) >>> MU_SHIFT);
    end
`endif

    assign x_ext = (W+1)'(voltage_level_in);

    always_comb begin
        pair_sum = '0;
        for (int i = 0; i < 3; i++) begin
            pair_sum = (W+2)'(lint[i]) + (W+2)'(lint[i+1]);
            thr[i]   = pair_sum[W+1:1];
        end
    end

    // A sample equal to a threshold belongs to the upper level.
    always_comb begin
        if (x_ext < thr[0]) begin
            sym_idx = 2'd0;
        end else if (x_ext < thr[1]) begin
            sym_idx = 2'd1;
        end else if (x_ext < thr[2]) begin
            sym_idx = 2'd2;
        end else begin
            sym_idx = 2'd3;
        end
        sel_dev  = (W+2)'(x_ext) - (W+2)'(lint[sym_idx]);
        sel_mag  = sel_dev[W+1] ? -sel_dev : sel_dev;
        marginal = sel_mag > MARGIN_X;
    end

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        win_d     = win_q;
        err_d     = err_q;
        lose_lock = 1'b0;
        err_inc   = (marginal && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
        if (voltage_level_in_valid) begin
            case (state_q)
                ACQUIRE: begin
                    if (marginal) begin
                        run_d = '0;
                    end else if (run_q == CW'(LOCK_COUNT - 1)) begin
                        run_d   = '0;
                        win_d   = '0;
                        err_d   = '0;
                        state_d = LOCKED;
                    end else begin
                        run_d = run_q + CW'(1);
                    end
                end
                LOCKED: begin
                    // Loss of lock takes priority over the window wrapping.
                    if (err_inc >= 8'(ERR_LIMIT)) begin
                        lose_lock = 1'b1;
                        state_d   = ACQUIRE;
                        run_d     = '0;
                        win_d     = '0;
                        err_d     = '0;
                    end else if (win_q == CW'(LOCK_COUNT - 1)) begin
                        win_d = '0;
                        err_d = '0;
                    end else begin
                        win_d = win_q + CW'(1);
                        err_d = err_inc;
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q          <= ACQUIRE;
            run_q            <= '0;
            win_q            <= '0;
            err_q            <= '0;
            symbol_out       <= '0;
            symbol_out_valid <= 1'b0;
            marginal_out     <= 1'b0;
        end else begin
            state_q          <= state_d;
            run_q            <= run_d;
            win_q            <= win_d;
            err_q            <= err_d;
            symbol_out_valid <= voltage_level_in_valid;
            if (voltage_level_in_valid) begin
                symbol_out   <= sym_idx;
                marginal_out <= marginal;
            end
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_count = err_q;

endmodule

// File: tb/tb_pam4_adaptive_slicer.sv
// Scoreboard bench for pam4_adaptive_slicer: arithmetic reference model feeds an
// expected queue, a negedge monitor pops and compares each emitted symbol.
module tb_pam4_adaptive_slicer;

    localparam int S = 56;

    logic              clk       = 1'b0;
    logic              rstn      = 1'b1;
    logic signed [7:0] vin       = '0;
    logic              vin_valid = 1'b0;
    logic [1:0]        symbol_out;
    logic              symbol_out_valid;
    logic              marginal_out;
    logic              locked;
    logic [7:0]        err_count;

    int checks = 0;
    int errors = 0;

    // {sym[1:0], marginal, locked, err_count[7:0]}
    logic [11:0] exp_q[$];

    int lv[4];
    bit m_locked;
    int m_run;
    int m_win;
    int m_err;
    bit adapt;

    bit prev_v   = 1'b0;
    bit prev_rst = 1'b0;

    pam4_adaptive_slicer dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .voltage_level_in      (vin),
        .voltage_level_in_valid(vin_valid),
        .symbol_out            (symbol_out),
        .symbol_out_valid      (symbol_out_valid),
        .marginal_out          (marginal_out),
        .locked                (locked),
        .err_count             (err_count)
    );

    always #5 clk = ~clk;

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int nom(input int i);
        return ((2 * i - 3) * S) / 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) lv[i] = nom(i) * 16;
        m_locked = 1'b0;
        m_run    = 0;
        m_win    = 0;
        m_err    = 0;
    endtask

    // Levels held in sixteenths; everything else as plain integers.
    task automatic model_step(input int x, output logic [11:0] e);
        int li[4];
        int t[3];
        int idx;
        int nv;
        bit marg;
        bit ok;
        for (int i = 0; i < 4; i++) li[i] = fdiv(lv[i], 16);
        for (int i = 0; i < 3; i++) t[i] = fdiv(li[i] + li[i+1], 2);
        idx = 3;
        for (int i = 2; i >= 0; i--) if (x < t[i]) idx = i;
        marg = ((x - li[idx]) > S / 4) || ((li[idx] - x) > S / 4);
        if (adapt) begin
            nv = lv[idx] + fdiv(x * 16 - lv[idx], 16);
            if (nv > 4095) nv = 4095;
            if (nv < -4096) nv = -4096;
            ok = 1'b1;
            if (idx > 0 && (nv - lv[idx-1]) < (S / 4) * 16) ok = 1'b0;
            if (idx < 3 && (lv[idx+1] - nv) < (S / 4) * 16) ok = 1'b0;
            if (ok) lv[idx] = nv;
        end
        if (!m_locked) begin
            if (marg) m_run = 0;
            else m_run = m_run + 1;
            if (m_run == 64) begin
                m_locked = 1'b1;
                m_run    = 0;
                m_win    = 0;
                m_err    = 0;
            end
        end else begin
            m_win = m_win + 1;
            if (marg && m_err < 255) m_err = m_err + 1;
            if (m_err >= 8) begin
                model_reset();
            end else if (m_win == 64) begin
                m_win = 0;
                m_err = 0;
            end
        end
        e = {2'(idx), marg, m_locked, 8'(m_err)};
    endtask

    task automatic drive(input bit v, input int x);
        logic [11:0] e;
        @(posedge clk);
        #1;
        vin_valid = v;
        vin       = 8'(x);
        if (v) begin
            model_step(x, e);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_reset(input int n);
        drive(1'b0, 0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rstn      = 1'b1;
            vin_valid = 1'($urandom_range(0, 1));
            vin       = 8'($urandom);
        end
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        vin_valid = 1'b0;
        model_reset();
    endtask

    always @(posedge clk) begin
        prev_v   <= vin_valid && !rstn;
        prev_rst <= rstn;
    end

    always @(negedge clk) begin
        logic [11:0] e;
        checks++;
        if (symbol_out_valid !== prev_v) begin
            errors++;
            $display("FAIL valid_timing: got %b expected %b at %0t", symbol_out_valid, prev_v, $time);
        end
        if (prev_rst) begin
            checks++;
            if ({symbol_out, symbol_out_valid, marginal_out, locked, err_count} !== 13'd0) begin
                errors++;
                $display("FAIL reset_state: got sym=%0d v=%b marg=%b lock=%b err=%0d expected all zero",
                         symbol_out, symbol_out_valid, marginal_out, locked, err_count);
            end
        end else if (symbol_out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_symbol: got sym=%0d with no expected entry", symbol_out);
            end else begin
                e = exp_q.pop_front();
                if ({symbol_out, marginal_out, locked, err_count} !== e) begin
                    errors++;
                    $display("FAIL symbol_out: got sym=%0d marg=%b lock=%b err=%0d expected sym=%0d marg=%b lock=%b err=%0d at %0t",
                             symbol_out, marginal_out, locked, err_count,
                             e[11:10], e[9], e[8], e[7:0], $time);
                end
            end
        end
    end

    initial begin
`ifdef PAM4_SLICER_ADAPT_EN
        adapt = 1'b1;
`else
        adapt = 1'b0;
`endif
        model_reset();
        pulse_reset(3);

        drive(1'b1, -84);
        repeat (64) drive(1'b1, nom(int'($urandom_range(0, 3))));

        repeat (400) drive(1'b1, nom(int'($urandom_range(0, 3))) + 10);
        drive(1'b1, 5);

        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1) drive(1'b1, 0);
            else drive(1'b1, nom(int'($urandom_range(0, 3))) + 10);
        end
        drive(1'b1, 0);

        for (int i = 0; i < 140; i++) begin
            drive(i % 2 == 0, nom(int'($urandom_range(0, 3))) + int'($urandom_range(0, 12)) - 6);
        end

        repeat (3) drive(1'b1, 0);
        pulse_reset(1);
        drive(1'b1, 0);
        drive(1'b1, -84);

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128);
        end

        drive(1'b0, 0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding symbols expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
